// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480 timing, derived totals and sync windows,
// and the {x, y} frame-buffer address packing used by scanout and rasterizer.
package vga_pkg;

    localparam int X_BITS     = 10;
    localparam int Y_BITS     = 9;
    localparam int ADDR_WIDTH = X_BITS + Y_BITS;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic SYNC_POL = 1'b0;

    // Column in the MSBs, row in the LSBs; the write path packs the same way.
    function automatic logic [ADDR_WIDTH-1:0] pack_addr(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y
    );
        return {x, y};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical position counters.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_TOT   = vga_pkg::H_TOTAL,
    parameter int V_TOT   = vga_pkg::V_TOTAL,
    parameter int H_CNT_W = $clog2(H_TOT + 1),
    parameter int V_CNT_W = $clog2(V_TOT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               tick,
    output logic               frame_wrap
);

    // One-bit divider when CLK_DIV is 1: it stays at 0 and tick is constant.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_cnt_reg;
    logic [H_CNT_W-1:0] h_cnt_reg;
    logic [V_CNT_W-1:0] v_cnt_reg;
    logic               h_last;
    logic               v_last;

    assign tick       = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign h_last     = (h_cnt_reg == H_CNT_W'(H_TOT - 1));
    assign v_last     = (v_cnt_reg == V_CNT_W'(V_TOT - 1));
    assign frame_wrap = tick & h_last & v_last;
    assign h_cnt      = h_cnt_reg;
    assign v_cnt      = v_cnt_reg;

    // Divide the system clock down to the pixel rate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    // Raster position: column wraps each line, row wraps each frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (tick) begin
            if (h_last) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= v_last ? '0 : v_cnt_reg + V_CNT_W'(1);
            end else begin
                h_cnt_reg <= h_cnt_reg + H_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: frame-buffer read addressing and registered display outputs.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int   ADDR_WIDTH = vga_pkg::ADDR_WIDTH,
    parameter int   X_BITS     = vga_pkg::X_BITS,
    parameter int   Y_BITS     = vga_pkg::Y_BITS,
    parameter int   CLK_DIV    = 2,
    parameter int   H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int   H_FP       = vga_pkg::H_FP,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BP       = vga_pkg::H_BP,
    parameter int   V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int   V_FP       = vga_pkg::V_FP,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BP       = vga_pkg::V_BP,
    parameter logic SYNC_POL   = vga_pkg::SYNC_POL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  pixel,
    output logic                  video_on,
    output logic                  vblank,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_CNT_W = $clog2(H_TOTAL + 1);
    localparam int V_CNT_W = $clog2(V_TOTAL + 1);

    localparam logic [H_CNT_W-1:0] H_VIS_C = H_CNT_W'(H_VISIBLE);
    localparam logic [H_CNT_W-1:0] H_SS_C  = H_CNT_W'(H_VISIBLE + H_FP);
    localparam logic [H_CNT_W-1:0] H_SE_C  = H_CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [V_CNT_W-1:0] V_VIS_C = V_CNT_W'(V_VISIBLE);
    localparam logic [V_CNT_W-1:0] V_SS_C  = V_CNT_W'(V_VISIBLE + V_FP);
    localparam logic [V_CNT_W-1:0] V_SE_C  = V_CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    generate
        if (X_BITS + Y_BITS != ADDR_WIDTH) begin : g_err_addr
            $error("vga_scanout: X_BITS + Y_BITS must equal ADDR_WIDTH");
        end
        if (H_VISIBLE > (1 << X_BITS) || V_VISIBLE > (1 << Y_BITS)) begin : g_err_vis
            $error("vga_scanout: visible area does not fit the address fields");
        end
        if (CLK_DIV < 1) begin : g_err_div
            $error("vga_scanout: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               tick;
    logic               frame_wrap;
    logic               visible;
    logic               in_hsync;
    logic               in_vsync;
    logic [X_BITS-1:0]  x_field;
    logic [Y_BITS-1:0]  y_field;

    logic hsync_reg;
    logic vsync_reg;
    logic pixel_reg;
    logic video_on_reg;
    logic frame_start_reg;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_TOT   (H_TOTAL),
        .V_TOT   (V_TOTAL),
        .H_CNT_W (H_CNT_W),
        .V_CNT_W (V_CNT_W)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .tick       (tick),
        .frame_wrap (frame_wrap)
    );

    assign visible  = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign in_hsync = (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
    assign in_vsync = (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);
    assign vblank   = (v_cnt >= V_VIS_C);

    // Row count runs past 2**Y_BITS in blanking, so the address is forced to 0 there.
    assign x_field = X_BITS'(h_cnt);
    assign y_field = Y_BITS'(v_cnt);
    assign rd_addr = visible ? {x_field, y_field} : '0;

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign pixel       = pixel_reg;
    assign video_on    = video_on_reg;
    assign frame_start = frame_start_reg;

    // Output stage: sample buffer data and sync windows once per pixel tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_reg    <= ~SYNC_POL;
            vsync_reg    <= ~SYNC_POL;
            pixel_reg    <= 1'b0;
            video_on_reg <= 1'b0;
        end else if (tick) begin
            hsync_reg    <= in_hsync ? SYNC_POL : ~SYNC_POL;
            vsync_reg    <= in_vsync ? SYNC_POL : ~SYNC_POL;
            pixel_reg    <= visible & rd_data;
            video_on_reg <= visible;
        end
    end

    // Single-clock pulse after the tick that wraps the raster back to (0,0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= frame_wrap;
        end
    end

endmodule
